uart_tx_buf: RTL

UART_TX_BUF -- requirements
Module: uart_tx_buf

---
 rtl/uart_tx_buf.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// UART transmitter with a one-byte holding buffer in front of a start/data/stop FSM.
// Latency: a write into an idle, empty block drives the start bit two edges after the write strobe.
// Backpressure: full is high while the buffer holds an unsent byte; writes during full are dropped.
module uart_tx_buf #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       full,
  output logic       busy,
  output logic       tx,
  output logic       tx_done_tick
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state, state_next;
  // 5-bit tick counter so stop lengths up to 32 ticks count without wrapping
  logic [4:0]      s, s_next;
  logic [2:0]      n, n_next;
  logic [DBIT-1:0] b, b_next;
  logic [7:0]      hold_q, hold_next;
  logic            full_next;
  logic            tx_next;
  logic            load;

  // the FSM pulls the buffered byte whenever it is idle and the buffer is occupied
  assign load = (state == IDLE) && full;
  assign busy = (state != IDLE);

  // state, counters, buffer and line register
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      s      <= '0;
      n      <= '0;
      b      <= '0;
      hold_q <= '0;
      full   <= 1'b0;
      tx     <= 1'b1;
    end else begin
      state  <= state_next;
      s      <= s_next;
      n      <= n_next;
      b      <= b_next;
      hold_q <= hold_next;
      full   <= full_next;
      tx     <= tx_next;
    end
  end

  // holding buffer: capture on a write into an empty buffer; the load clears it and
  // wins over a same-cycle write because full is still high during that cycle
  always_comb begin
    hold_next = hold_q;
    full_next = full;
    if (load) begin
      full_next = 1'b0;
    end else if (wr_en && !full) begin
      hold_next = din;
      full_next = 1'b1;
    end
  end

  // next-state, counters, done pulse and the registered line level for the next state
  always_comb begin
    state_next   = state;
    s_next       = s;
    n_next       = n;
    b_next       = b;
    tx_done_tick = 1'b0;
    case (state)
      IDLE: begin
        if (full) begin
          b_next     = hold_q[DBIT-1:0];
          s_next     = '0;
          state_next = START;
        end
      end
      START: begin
        if (s_tick) begin
          if (s == 5'd15) begin
            s_next     = '0;
            n_next     = '0;
            state_next = DATA;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (s == 5'd15) begin
            s_next = '0;
            b_next = {1'b0, b[DBIT-1:1]};
            if (n == 3'(DBIT - 1)) begin
              state_next = STOP;
            end else begin
              n_next = n + 3'd1;
            end
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      STOP: begin
        if (s_tick) begin
          if (s == 5'(SB_TICK - 1)) begin
            tx_done_tick = 1'b1;
            state_next   = IDLE;
          end else begin
            s_next = s + 5'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // line level follows the state being entered so tx changes in its first clock
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = b_next[0];
      default: tx_next = 1'b1;
    endcase
  end

endmodule
